// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer.
// Fetch-side lookup is purely combinational; training happens at the clock edge
// from the resolved branch in the Memory stage. Each set keeps one lru bit that
// names the way to replace next.
module btb_2way #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        pcsrcPF,
  output logic        hitF,
  output logic [31:0] targetF,
  output logic        pred_takenF,
  output logic [31:0] pc_nextPF,
  input  logic        branchM,
  input  logic        flushM,
  input  logic [31:0] pcM,
  input  logic        pcsrcM,
  input  logic [31:0] branch_targetM,
  input  logic        invalidate
);

  localparam int SETS    = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = INDEX_WIDTH + 2;
  localparam int TAG_MSB = INDEX_WIDTH + TAG_WIDTH + 1;

  logic [SETS-1:0]      valid0_q, valid0_d;
  logic [SETS-1:0]      valid1_q, valid1_d;
  logic [SETS-1:0]      lru_q, lru_d;
  logic [TAG_WIDTH-1:0] tag0_q [SETS];
  logic [TAG_WIDTH-1:0] tag1_q [SETS];
  logic [31:0]          tgt0_q [SETS];
  logic [31:0]          tgt1_q [SETS];

  logic [INDEX_WIDTH-1:0] idx_f, idx_m;
  logic [TAG_WIDTH-1:0]   tag_f, tag_m;
  logic                   hit0_f, hit1_f;
  logic                   hit0_m, hit1_m;
  logic                   upd;
  logic                   alloc_way;
  logic                   wr0_en, wr1_en;
  logic                   unused_pcm;

  assign idx_f = pcF[INDEX_WIDTH+1:2];
  assign tag_f = pcF[TAG_MSB:TAG_LSB];
  assign idx_m = pcM[INDEX_WIDTH+1:2];
  assign tag_m = pcM[TAG_MSB:TAG_LSB];
  assign upd   = branchM & ~flushM;

  // Bits of the M-stage PC outside the index/tag window take no part in matching.
  assign unused_pcm = ^{pcM[1:0], pcM[31:TAG_MSB+1]};

  // Fetch lookup: way0 wins if both ways somehow match; misses report a zero target.
  always_comb begin
    hit0_f      = valid0_q[idx_f] && (tag0_q[idx_f] == tag_f);
    hit1_f      = valid1_q[idx_f] && (tag1_q[idx_f] == tag_f);
    hitF        = hit0_f | hit1_f;
    targetF     = 32'd0;
    if (hit0_f) begin
      targetF = tgt0_q[idx_f];
    end else if (hit1_f) begin
      targetF = tgt1_q[idx_f];
    end
    pred_takenF = hitF & pcsrcPF;
    pc_nextPF   = pred_takenF ? targetF : pcF + 32'd4;
  end

  // Training: refresh or retarget on a hit, allocate only taken misses, invalidate wins.
  always_comb begin
    valid0_d  = valid0_q;
    valid1_d  = valid1_q;
    lru_d     = lru_q;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    alloc_way = 1'b0;
    hit0_m    = valid0_q[idx_m] && (tag0_q[idx_m] == tag_m);
    hit1_m    = valid1_q[idx_m] && (tag1_q[idx_m] == tag_m);
    if (invalidate) begin
      valid0_d = '0;
      valid1_d = '0;
      lru_d    = '0;
    end else if (upd) begin
      if (hit0_m) begin
        wr0_en       = pcsrcM;
        lru_d[idx_m] = 1'b1;
      end else if (hit1_m) begin
        wr1_en       = pcsrcM;
        lru_d[idx_m] = 1'b0;
      end else if (pcsrcM) begin
        if (!valid0_q[idx_m]) begin
          alloc_way = 1'b0;
        end else if (!valid1_q[idx_m]) begin
          alloc_way = 1'b1;
        end else begin
          alloc_way = lru_q[idx_m];
        end
        if (alloc_way) begin
          wr1_en          = 1'b1;
          valid1_d[idx_m] = 1'b1;
        end else begin
          wr0_en          = 1'b1;
          valid0_d[idx_m] = 1'b1;
        end
        lru_d[idx_m] = ~alloc_way;
      end
    end
  end

  // Valid and lru bits clear immediately on reset so every entry reads invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  // Tag and target storage is only meaningful behind a valid bit, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      tag0_q[idx_m] <= tag_m;
      tgt0_q[idx_m] <= branch_targetM;
    end
    if (wr1_en) begin
      tag1_q[idx_m] <= tag_m;
      tgt1_q[idx_m] <= branch_targetM;
    end
  end

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the buffer kept in the bench.
module tb_btb_2way;

  localparam int IW   = 6;
  localparam int TW   = 8;
  localparam int SETS = 1 << IW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        pcsrcPF;
  logic        hitF;
  logic [31:0] targetF;
  logic        pred_takenF;
  logic [31:0] pc_nextPF;
  logic        branchM;
  logic        flushM;
  logic [31:0] pcM;
  logic        pcsrcM;
  logic [31:0] branch_targetM;
  logic        invalidate;

  int tests_run    = 0;
  int tests_failed = 0;

  bit          m_valid [SETS][2];
  bit [TW-1:0] m_tag   [SETS][2];
  bit [31:0]   m_tgt   [SETS][2];
  bit          m_lru   [SETS];

  btb_2way #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .pcsrcPF(pcsrcPF), .hitF(hitF),
    .targetF(targetF), .pred_takenF(pred_takenF), .pc_nextPF(pc_nextPF),
    .branchM(branchM), .flushM(flushM), .pcM(pcM), .pcsrcM(pcsrcM),
    .branch_targetM(branch_targetM), .invalidate(invalidate)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[IW+1:2]);
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [31:0] pc);
    return pc[IW+TW+1:IW+2];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endtask

  // Compare all fetch outputs against what the model predicts for the current pcF.
  task automatic checkLookup();
    int          s;
    bit          e_hit;
    bit [31:0]   e_tgt;
    bit          e_taken;
    bit [31:0]   e_next;
    s     = idx_of(pcF);
    e_hit = 1'b0;
    e_tgt = 32'd0;
    for (int w = 0; w < 2; w++) begin
      if (!e_hit && m_valid[s][w] && m_tag[s][w] == tag_of(pcF)) begin
        e_hit = 1'b1;
        e_tgt = m_tgt[s][w];
      end
    end
    e_taken = e_hit & pcsrcPF;
    e_next  = e_taken ? e_tgt : pcF + 32'd4;
    checkOutput("hitF", {31'd0, hitF}, {31'd0, e_hit});
    checkOutput("targetF", targetF, e_tgt);
    checkOutput("pred_takenF", {31'd0, pred_takenF}, {31'd0, e_taken});
    checkOutput("pc_nextPF", pc_nextPF, e_next);
  endtask

  task automatic modelUpdate(input bit br, input bit fl, input logic [31:0] pc, input bit taken,
                             input logic [31:0] tgt, input bit inv);
    int s;
    int w;
    s = idx_of(pc);
    if (inv) begin
      modelReset();
    end else if (br && !fl) begin
      w = -1;
      if (m_valid[s][0] && m_tag[s][0] == tag_of(pc)) w = 0;
      else if (m_valid[s][1] && m_tag[s][1] == tag_of(pc)) w = 1;
      if (w >= 0) begin
        if (taken) m_tgt[s][w] = tgt;
        m_lru[s] = (w == 0);
      end else if (taken) begin
        if (!m_valid[s][0]) w = 0;
        else if (!m_valid[s][1]) w = 1;
        else w = int'(m_lru[s]);
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = tag_of(pc);
        m_tgt[s][w]   = tgt;
        m_lru[s]      = (w == 0);
      end
    end
  endtask

  // One cycle: drive at the falling edge, check the pre-write lookup, then train the model.
  task automatic applyStimulus(input logic [31:0] pcf, input bit psf, input bit br, input bit fl,
                               input logic [31:0] pcm, input bit psm, input logic [31:0] tgt,
                               input bit inv);
    @(negedge clk);
    pcF            = pcf;
    pcsrcPF        = psf;
    branchM        = br;
    flushM         = fl;
    pcM            = pcm;
    pcsrcM         = psm;
    branch_targetM = tgt;
    invalidate     = inv;
    #1;
    checkLookup();
    @(posedge clk);
    modelUpdate(br, fl, pcm, psm, tgt, inv);
  endtask

  task automatic fetch(input logic [31:0] pcf, input bit psf);
    applyStimulus(pcf, psf, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #1;
  endtask

  task automatic train(input logic [31:0] pcm, input bit psm, input logic [31:0] tgt, input bit fl);
    applyStimulus(32'h0000_1000, 1'b0, 1'b1, fl, pcm, psm, tgt, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    int          sel;
    logic [IW-1:0] idx;
    r   = $urandom;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       idx = 6'd4;
      1:       idx = 6'd5;
      2:       idx = 6'd9;
      default: idx = 6'd63;
    endcase
    return {r[31:16], 6'd0, 2'($urandom_range(0, 3)), idx, 2'b00};
  endfunction

  task automatic randomTraffic(input int cycles);
    logic [31:0] pcf;
    logic [31:0] pcm;
    logic [31:0] tgt;
    for (int i = 0; i < cycles; i++) begin
      pcm = rand_pc() | 32'($urandom_range(0, 3));
      pcf = ($urandom_range(0, 3) == 0) ? {pcm[31:2], 2'b00} : rand_pc();
      tgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus(pcf, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 6) == 0, pcm, $urandom_range(0, 2) != 0, tgt,
                    $urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    pcF = 32'h0040_0010;
    pcsrcPF = 1'b1;
    branchM = 1'b0;
    flushM = 1'b0;
    pcM = 32'd0;
    pcsrcM = 1'b0;
    branch_targetM = 32'd0;
    invalidate = 1'b0;
    modelReset();
    #3;
    checkOutput("reset_hitF", {31'd0, hitF}, 32'd0);
    checkOutput("reset_targetF", targetF, 32'd0);
    checkOutput("reset_pred_takenF", {31'd0, pred_takenF}, 32'd0);
    checkOutput("reset_pc_nextPF", pc_nextPF, 32'h0040_0014);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    fetch(32'h0040_0010, 1'b1);
    checkOutput("cold_miss_next", pc_nextPF, 32'h0040_0014);
    train(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    fetch(32'h0040_0010, 1'b1);
    checkOutput("hit_taken_next", pc_nextPF, 32'h0040_0100);
    fetch(32'h0040_0010, 1'b0);
    checkOutput("hit_not_taken_next", pc_nextPF, 32'h0040_0014);

    train(32'h0040_0110, 1'b1, 32'h0040_0500, 1'b0);
    train(32'h0040_0210, 1'b1, 32'h0040_0600, 1'b0);
    fetch(32'h0040_0010, 1'b1);
    checkOutput("evicted_miss", {31'd0, hitF}, 32'd0);
    fetch(32'h0040_0110, 1'b1);
    checkOutput("way1_survives", pc_nextPF, 32'h0040_0500);
    fetch(32'h0040_0210, 1'b1);
    checkOutput("new_alloc_hit", pc_nextPF, 32'h0040_0600);

    train(32'h0040_0310, 1'b0, 32'h0040_0700, 1'b0);
    fetch(32'h0040_0310, 1'b1);
    checkOutput("not_taken_no_alloc", {31'd0, hitF}, 32'd0);
    train(32'h0040_0310, 1'b1, 32'h0040_0700, 1'b1);
    fetch(32'h0040_0310, 1'b1);
    checkOutput("flush_no_alloc", {31'd0, hitF}, 32'd0);
    train(32'h0040_0410, 1'b1, 32'h0040_0900, 1'b0);
    fetch(32'h0040_0110, 1'b1);
    checkOutput("lru_kept_victim", {31'd0, hitF}, 32'd0);
    fetch(32'h0040_0210, 1'b1);
    checkOutput("lru_kept_mru", {31'd0, hitF}, 32'd1);

    train(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    @(negedge clk);
    pcF = 32'h0040_0010;
    pcsrcPF = 1'b1;
    branchM = 1'b1;
    flushM = 1'b0;
    pcM = 32'h0040_0010;
    pcsrcM = 1'b1;
    branch_targetM = 32'h0040_0800;
    invalidate = 1'b0;
    #1;
    checkOutput("no_bypass_old_target", targetF, 32'h0040_0100);
    checkLookup();
    @(posedge clk);
    modelUpdate(1'b1, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0800, 1'b0);
    fetch(32'h0040_0010, 1'b1);
    checkOutput("retarget_visible", targetF, 32'h0040_0800);

    fetch(32'hFFFF_FFFC, 1'b1);
    checkOutput("pc_wrap", pc_nextPF, 32'h0000_0000);

    applyStimulus(32'h0040_0010, 1'b1, 1'b1, 1'b0, 32'h0040_0510, 1'b1, 32'h0040_0A00, 1'b1);
    fetch(32'h0040_0010, 1'b1);
    checkOutput("invalidate_old", {31'd0, hitF}, 32'd0);
    fetch(32'h0040_0510, 1'b1);
    checkOutput("invalidate_beats_update", {31'd0, hitF}, 32'd0);

    randomTraffic(400);

    train(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    fetch(32'h0040_0010, 1'b1);
    checkOutput("pre_reset_hit", {31'd0, hitF}, 32'd1);
    @(negedge clk);
    branchM = 1'b1;
    flushM = 1'b0;
    pcM = 32'h0040_0610;
    pcsrcM = 1'b1;
    branch_targetM = 32'h0040_0B00;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_hitF", {31'd0, hitF}, 32'd0);
    checkOutput("async_reset_next", pc_nextPF, 32'h0040_0014);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    branchM = 1'b0;
    fetch(32'h0040_0610, 1'b1);
    checkOutput("reset_discards_update", {31'd0, hitF}, 32'd0);

    randomTraffic(400);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
